vga_sync_decoder: RTL and testbench
===================================

# vga_sync_decoder

Receive-side counterpart of the VGA 640x480@60 sync generator. Samples active-low hsync/vsync in the pixel clock domain, recovers hpos/vpos and display_on, and reports lock status and timing errors. Used as the checker/timing recovery at the capture end of the video path and as a self-check in the display bench.

## Interface
Parameters:
- H_DISPLAY, 640: visible pixels per line
- H_FRONT, 16 / H_SYNC, 96 / H_BACK, 48: horizontal porches and sync width
- V_DISPLAY, 480: visible lines
- V_FRONT, 10 / V_SYNC, 2 / V_BACK, 33: vertical porches and sync width
- LOCK_FRAMES, 2: consecutive clean frames required to assert locked (1..15)

Ports:
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- hsync_in  in  1  horizontal sync, active low
- vsync_in  in  1  vertical sync, active low
- hpos  out  10  recovered column, 0..H_MAX
- vpos  out  10  recovered row, 0..V_MAX
- display_on  out  1  locked and inside visible area
- locked  out  1  timing lock achieved
- frame_start  out  1  one-cycle pulse when hpos/vpos wrap to 0/0
- line_err  out  1  one-cycle pulse, hsync edge at wrong column or sync width wrong
- frame_err  out  1  one-cycle pulse, vsync edge at wrong row
- line_err_count, frame_err_count  out  16 each  error counters (see Configuration)

Derived: H_MAX = H_DISPLAY+H_FRONT+H_SYNC+H_BACK-1 (799); H_SYNC_START = H_DISPLAY+H_FRONT (656); V_MAX = 524; V_SYNC_START = V_DISPLAY+V_FRONT (490).

## Operation
- Edge detect: hsync_q/vsync_q hold the previous sample; falling edge = q==1 and in==0; rising edge = q==0 and in==1. Both q regs reset to 1.
- hpos free-runs, wraps H_MAX->0; vpos increments on the hpos wrap, wraps V_MAX->0.
- Alignment: in the cycle hsync_in is first sampled low, the required hpos is H_SYNC_START. On an hsync falling edge, if hpos != H_SYNC_START: pulse line_err, load hpos <= H_SYNC_START+1. Otherwise count normally.
- Sync width: on an hsync rising edge, low duration must equal H_SYNC cycles, else line_err.
- On a vsync falling edge, if vpos != V_SYNC_START: pulse frame_err, load vpos <= V_SYNC_START (hpos unchanged). Vertical edge may fall at any column.
- Both horizontal errors in one cycle -> a single line_err pulse.
- Lock FSM:
  - SEARCH: locked=0. First vsync falling edge -> TRACK, good=0.
  - TRACK: at each vsync falling edge with no line_err/frame_err since the previous one, good+1; good reaching LOCK_FRAMES -> LOCKED. Any error -> good=0, stay.
  - LOCKED: locked=1. Any error -> TRACK, good=0.
  - Any state: no hsync falling edge for 2*(H_MAX+1) cycles -> SEARCH (watchdog).
- display_on = locked && hpos<H_DISPLAY && vpos<V_DISPLAY, combinational from registers.
- frame_start = locked && hpos==0 && vpos==0.

## Timing
- Reset (clk edge with reset=1): hpos=0, vpos=0, locked=0, line_err=0, frame_err=0, counters=0, state SEARCH, watchdog=0. Reset overrides everything, including mid-frame.
- Error pulses are registered: asserted in the cycle after the offending edge sample, for exactly one cycle.
- hpos/vpos resync takes effect in the cycle after the edge.
- locked rises in the cycle after the LOCK_FRAMES-th clean vsync edge. It falls in the cycle after an error pulse's cause. From a clean generator after reset, locked rises after the (LOCK_FRAMES+1)-th vsync falling edge.
- Watchdog counter is 11 bits and clears on every hsync falling edge.

## Configuration
- VGA_SYNC_DECODER_STATS_EN defined: line_err_count/frame_err_count increment on each line_err/frame_err pulse. They saturate at 0xFFFF and clear only on reset.
- Not defined: counter logic is omitted, and both ports are tied to 0. All other behaviour is identical.

## Structure
- Package vga_timing_pkg: the H_*/V_* default constants, the derived H_MAX/V_MAX/H_SYNC_START/V_SYNC_START, and the lock-state enum (SEARCH, TRACK, LOCKED). Shared with the sync generator.
- Sub-module vga_edge_detect: one-bit sample register plus rise/fall outputs, reset value 1. Instantiated once for hsync and once for vsync.

## Test plan
- Clean generator stream after reset: locked rises after the 3rd vsync fall; afterwards hpos/vpos track the generator with a fixed offset, and line_err/frame_err stay 0 for 5 frames.
- Shift one hsync fall by +3 columns while locked: one line_err pulse, locked drops, and hpos==657 in the cycle after. Relock follows after 2 clean frames.
- hsync low pulse of 95 cycles: line_err on the rising edge, vpos unaffected.
- vsync fall at row 489: frame_err pulse, vpos loads 490, state TRACK with good=0.
- Hold hsync_in high for 1600 cycles: state returns to SEARCH, locked=0, display_on=0.
- Assert reset mid-frame (hpos=300, vpos=200): next cycle hpos=0, vpos=0, locked=0. With STATS_EN, after 3 injected line errors, line_err_count=3 before reset and 0 after.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and the lock-state encoding used by
// both the sync generator and the receive-side sync decoder.
package vga_timing_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_MAX        = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
  localparam int V_MAX        = V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int V_SYNC_START = V_DISPLAY + V_FRONT;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } lock_state_e;

endpackage

// File: rtl/vga_edge_detect.sv
// One-bit sample register with rise/fall detection; idles high so an
// active-low sync that is already low after reset reports a fall.
module vga_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (reset) sig_q <= 1'b1;
    else       sig_q <= sig_in;
  end

  assign fall = sig_q & ~sig_in;
  assign rise = ~sig_q & sig_in;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers hpos/vpos/display_on from active-low hsync/vsync, tracks timing lock
// and flags misplaced edges. Error counters exist only with VGA_SYNC_DECODER_STATS_EN.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY   = vga_timing_pkg::H_DISPLAY,
  parameter int H_FRONT     = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BACK      = vga_timing_pkg::H_BACK,
  parameter int V_DISPLAY   = vga_timing_pkg::V_DISPLAY,
  parameter int V_FRONT     = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BACK      = vga_timing_pkg::V_BACK,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [9:0]  hpos,
  output logic [9:0]  vpos,
  output logic        display_on,
  output logic        locked,
  output logic        frame_start,
  output logic        line_err,
  output logic        frame_err,
  output logic [15:0] line_err_count,
  output logic [15:0] frame_err_count,
  output logic [1:0]  lock_state,
  output logic [3:0]  good_count,
  output logic [3:0]  sync_edges
);

  localparam int          H_MAX_I   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1;
  localparam logic [9:0]  H_MAX_C   = 10'(H_MAX_I);
  localparam logic [9:0]  H_SS_C    = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0]  H_DISP_C  = 10'(H_DISPLAY);
  localparam logic [9:0]  V_MAX_C   = 10'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0]  V_SS_C    = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0]  V_DISP_C  = 10'(V_DISPLAY);
  localparam logic [7:0]  H_SYNC_C  = 8'(H_SYNC);
  localparam logic [10:0] WD_LAST   = 11'(2 * (H_MAX_I + 1) - 1);
  localparam logic [3:0]  LOCK_C    = 4'(LOCK_FRAMES);

  logic h_rise, h_fall, v_rise, v_fall;

  vga_edge_detect u_hsync_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_in (hsync_in),
    .rise   (h_rise),
    .fall   (h_fall)
  );

  vga_edge_detect u_vsync_edge (
    .clk    (clk),
    .reset  (reset),
    .sig_in (vsync_in),
    .rise   (v_rise),
    .fall   (v_fall)
  );

  assign sync_edges = {h_rise, h_fall, v_rise, v_fall};

  // Low-time of the current hsync pulse, counting the falling-edge sample as 1.
  logic [7:0] hlow_cnt;

  always_ff @(posedge clk) begin
    if (reset)                                 hlow_cnt <= 8'd0;
    else if (h_fall)                           hlow_cnt <= 8'd1;
    else if (!hsync_in && hlow_cnt != 8'hFF)   hlow_cnt <= hlow_cnt + 8'd1;
  end

  logic h_pos_err, h_width_err, line_err_d, frame_err_d, err_now, h_wrap;

  assign h_pos_err   = h_fall && (hpos != H_SS_C);
  assign h_width_err = h_rise && (hlow_cnt != H_SYNC_C);
  assign line_err_d  = h_pos_err | h_width_err;
  assign frame_err_d = v_fall && (vpos != V_SS_C);
  assign err_now     = line_err_d | frame_err_d;
  assign h_wrap      = (hpos == H_MAX_C) && !h_pos_err;

  // A misplaced hsync fall means the current column is really H_SYNC_START,
  // so the next one is H_SYNC_START+1; vertical resync leaves hpos alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos      <= 10'd0;
      vpos      <= 10'd0;
      line_err  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      line_err  <= line_err_d;
      frame_err <= frame_err_d;
      if (h_pos_err)              hpos <= H_SS_C + 10'd1;
      else if (hpos == H_MAX_C)   hpos <= 10'd0;
      else                        hpos <= hpos + 10'd1;
      if (frame_err_d)            vpos <= V_SS_C;
      else if (h_wrap)            vpos <= (vpos == V_MAX_C) ? 10'd0 : vpos + 10'd1;
    end
  end

  // Watchdog saturates once expired so the FSM stays parked in SEARCH.
  logic [10:0] wd_cnt;
  logic        wd_timeout;

  assign wd_timeout = (wd_cnt == WD_LAST) && !h_fall;

  always_ff @(posedge clk) begin
    if (reset)             wd_cnt <= 11'd0;
    else if (h_fall)       wd_cnt <= 11'd0;
    else if (!wd_timeout)  wd_cnt <= wd_cnt + 11'd1;
  end

  lock_state_e state, state_n;
  logic [3:0]  good, good_n;
  logic        err_seen, err_seen_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SEARCH;
      good     <= 4'd0;
      err_seen <= 1'b0;
    end else begin
      state    <= state_n;
      good     <= good_n;
      err_seen <= err_seen_n;
    end
  end

  // An error coinciding with a vsync fall belongs to the frame that edge closes.
  always_comb begin
    state_n    = state;
    good_n     = good;
    err_seen_n = err_seen;
    if (v_fall)       err_seen_n = 1'b0;
    else if (err_now) err_seen_n = 1'b1;
    case (state)
      SEARCH: begin
        if (v_fall) begin
          state_n = TRACK;
          good_n  = 4'd0;
        end
      end
      TRACK: begin
        if (err_now) begin
          good_n = 4'd0;
        end else if (v_fall) begin
          if (err_seen) begin
            good_n = 4'd0;
          end else begin
            good_n = good + 4'd1;
            if (good + 4'd1 >= LOCK_C) state_n = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (err_now) begin
          state_n = TRACK;
          good_n  = 4'd0;
        end
      end
      default: begin
        state_n = SEARCH;
        good_n  = 4'd0;
      end
    endcase
    if (wd_timeout) begin
      state_n = SEARCH;
      good_n  = 4'd0;
    end
  end

  assign locked      = (state == LOCKED);
  assign display_on  = locked && (hpos < H_DISP_C) && (vpos < V_DISP_C);
  assign frame_start = locked && (hpos == 10'd0) && (vpos == 10'd0);
  assign lock_state  = state;
  assign good_count  = good;

`ifdef VGA_SYNC_DECODER_STATS_EN
  logic [15:0] line_cnt_q, frame_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      line_cnt_q  <= 16'd0;
      frame_cnt_q <= 16'd0;
    end else begin
      if (line_err && line_cnt_q != 16'hFFFF)   line_cnt_q  <= line_cnt_q + 16'd1;
      if (frame_err && frame_cnt_q != 16'hFFFF) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign line_err_count  = line_cnt_q;
  assign frame_err_count = frame_cnt_q;
`else
  assign line_err_count  = 16'd0;
  assign frame_err_count = 16'd0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down raster (32x15 total,
// hsync start 20 width 8, vsync start row 10) so many frames fit in a short run.
module tb_vga_sync_decoder;
  import vga_timing_pkg::*;

  localparam int HD = 16, HF = 4, HS = 8, HB = 4;
  localparam int VD = 8, VF = 2, VS = 2, VB = 3;
  localparam int H_TOT = HD + HF + HS + HB;
  localparam int V_TOT = VD + VF + VS + VB;
  localparam int HSS = HD + HF;
  localparam int VSS = VD + VF;
`ifdef VGA_SYNC_DECODER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk, reset, hsync_in, vsync_in;
  logic [9:0]  hpos, vpos;
  logic        display_on, locked, frame_start, line_err, frame_err;
  logic [15:0] line_err_count, frame_err_count;
  logic [1:0]  lock_state;
  logic [3:0]  good_count, sync_edges;

  vga_sync_decoder #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hpos(hpos), .vpos(vpos), .display_on(display_on), .locked(locked),
    .frame_start(frame_start), .line_err(line_err), .frame_err(frame_err),
    .line_err_count(line_err_count), .frame_err_count(frame_err_count),
    .lock_state(lock_state), .good_count(good_count), .sync_edges(sync_edges)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int gh, gv;
  bit skip_line, short_pulse, hs_hold, mon_en;
  int mon_errs, mon_track;
  int exp_line, exp_frame;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference generator: sync levels from the bench's own raster position.
  task automatic drive();
    int h_end;
    h_end    = HSS + HS - (short_pulse ? 1 : 0);
    hsync_in = (hs_hold || !(gh >= HSS && gh < h_end)) ? 1'b1 : 1'b0;
    vsync_in = (gv >= VSS && gv < VSS + VS) ? 1'b0 : 1'b1;
  endtask

  task automatic tick(input bit adv);
    @(posedge clk);
    #1;
    if (adv) begin
      if (gh == H_TOT - 1) begin
        gh = 0;
        if (gv == V_TOT - 1) gv = 0;
        else if (skip_line && gv == VSS - 2) begin
          gv = VSS;
          skip_line = 1'b0;
        end else gv++;
      end else gh++;
    end
    if (mon_en) begin
      if (line_err || frame_err) mon_errs++;
      if (int'(hpos) != gh || int'(vpos) != gv) mon_track++;
    end
    drive();
  endtask

  task automatic run_until(input int tv, input int th);
    int n;
    n = 0;
    while (!(gv == tv && gh == th)) begin
      if (n > 2000) begin
        check("run_until_timeout", 32'd0, 32'd1);
        return;
      end
      tick(1'b1);
      n++;
    end
  endtask

  task automatic wait_vfall();
    run_until(VSS, 0);
    tick(1'b1);
  endtask

  // Generator stalls 3 columns before its hsync fall, so the fall lands at hpos HSS+3.
  task automatic do_shift(input string tag);
    run_until(2, HSS - 1);
    repeat (3) tick(1'b0);
    tick(1'b1);
    check({tag, "_pre_hpos"}, 32'(hpos), 32'(HSS + 3));
    tick(1'b1);
    exp_line++;
    check({tag, "_line_err"}, 32'(line_err), 32'd1);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_hpos"}, 32'(hpos), 32'(HSS + 1));
    tick(1'b1);
    check({tag, "_pulse_end"}, 32'(line_err), 32'd0);
  endtask

  task automatic relock3(input string tag);
    wait_vfall();
    check({tag, "_good0"}, 32'(good_count), 32'd0);
    wait_vfall();
    check({tag, "_good1"}, 32'(good_count), 32'd1);
    check({tag, "_not_yet"}, 32'(locked), 32'd0);
    wait_vfall();
    check({tag, "_locked"}, 32'(locked), 32'd1);
  endtask

  initial begin
    gh = 0; gv = 0;
    skip_line = 0; short_pulse = 0; hs_hold = 0; mon_en = 0;
    mon_errs = 0; mon_track = 0; exp_line = 0; exp_frame = 0;
    reset = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hpos", 32'(hpos), 32'd0);
    check("rst_vpos", 32'(vpos), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_line_err", 32'(line_err), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_state", 32'(lock_state), 32'(SEARCH));
    check("rst_line_cnt", 32'(line_err_count), 32'd0);
    reset = 1'b0;
    drive();

    // Acquire: SEARCH -> TRACK on 1st fall, LOCKED after the 3rd.
    wait_vfall();
    check("acq_track", 32'(lock_state), 32'(TRACK));
    check("acq_good0", 32'(good_count), 32'd0);
    wait_vfall();
    check("acq_good1", 32'(good_count), 32'd1);
    run_until(VSS, 0);
    check("acq_pre3", 32'(locked), 32'd0);
    tick(1'b1);
    check("acq_locked", 32'(locked), 32'd1);

    // Five clean frames: no error pulses, position tracks the generator.
    mon_en = 1'b1;
    repeat (5 * H_TOT * V_TOT) tick(1'b1);
    mon_en = 1'b0;
    check("clean_err_pulses", 32'(mon_errs), 32'd0);
    check("clean_track_off", 32'(mon_track), 32'd0);
    run_until(0, 0);
    check("frame_start", 32'(frame_start), 32'd1);
    check("disp_on_origin", 32'(display_on), 32'd1);
    tick(1'b1);
    check("frame_start_end", 32'(frame_start), 32'd0);
    run_until(4, HD - 1);
    check("disp_last_col", 32'(display_on), 32'd1);
    tick(1'b1);
    check("disp_past_col", 32'(display_on), 32'd0);
    run_until(VD, 0);
    check("disp_past_row", 32'(display_on), 32'd0);

    // Misplaced hsync fall, then relock over two clean frames.
    do_shift("shift1");
    relock3("relock1");

    // hsync pulse one cycle short: error on the rising edge only.
    run_until(3, HSS - 1);
    short_pulse = 1'b1;
    drive();
    run_until(3, HSS + HS - 1);
    check("short_pre_err", 32'(line_err), 32'd0);
    tick(1'b1);
    exp_line++;
    check("short_line_err", 32'(line_err), 32'd1);
    check("short_vpos", 32'(vpos), 32'd3);
    check("short_hpos", 32'(hpos), 32'(HSS + HS));
    check("short_locked", 32'(locked), 32'd0);
    short_pulse = 1'b0;
    relock3("relock2");

    // vsync falls one row early (generator skips a line).
    skip_line = 1'b1;
    run_until(VSS, 0);
    check("vearly_vpos_pre", 32'(vpos), 32'(VSS - 1));
    tick(1'b1);
    exp_frame++;
    check("vearly_frame_err", 32'(frame_err), 32'd1);
    check("vearly_vpos", 32'(vpos), 32'(VSS));
    check("vearly_hpos", 32'(hpos), 32'd1);
    check("vearly_state", 32'(lock_state), 32'(TRACK));
    check("vearly_good", 32'(good_count), 32'd0);
    wait_vfall();
    check("vearly_good1", 32'(good_count), 32'd1);
    wait_vfall();
    check("vearly_relock", 32'(locked), 32'd1);

    // Watchdog: no hsync fall for 2 full lines.
    run_until(1, 0);
    check("wd_disp_before", 32'(display_on), 32'd1);
    hs_hold = 1'b1;
    drive();
    repeat (2 * H_TOT) tick(1'b1);
    check("wd_state", 32'(lock_state), 32'(SEARCH));
    check("wd_locked", 32'(locked), 32'd0);
    check("wd_disp", 32'(display_on), 32'd0);
    hs_hold = 1'b0;
    drive();
    relock3("relock3");

    // Third injected line error, then counters.
    do_shift("shift2");
    check("line_err_count", 32'(line_err_count), STATS ? 32'(exp_line) : 32'd0);
    check("frame_err_count", 32'(frame_err_count), STATS ? 32'(exp_frame) : 32'd0);
    relock3("relock4");

    // Reset mid-frame.
    run_until(5, 10);
    check("mid_locked", 32'(locked), 32'd1);
    check("mid_hpos", 32'(hpos), 32'd10);
    check("mid_vpos", 32'(vpos), 32'd5);
    reset = 1'b1;
    tick(1'b1);
    check("mrst_hpos", 32'(hpos), 32'd0);
    check("mrst_vpos", 32'(vpos), 32'd0);
    check("mrst_locked", 32'(locked), 32'd0);
    check("mrst_state", 32'(lock_state), 32'(SEARCH));
    check("mrst_line_cnt", 32'(line_err_count), 32'd0);
    check("mrst_frame_cnt", 32'(frame_err_count), 32'd0);
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
